// File: rtl/compress_tile_predict_pkg.sv
// Shared types and helpers for the tile prediction stage: channel codes,
// default tile edge, zigzag coding and residual bit-length measurement.
package compress_pkg;

    localparam int TILE_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        CH_B = 2'd0,
        CH_G = 2'd1,
        CH_R = 2'd2,
        CH_A = 2'd3
    } chan_e;

    // Folds a signed 8-bit difference so small magnitudes of either sign
    // map onto small unsigned codes.
    function automatic logic [7:0] zigzag8(input logic [7:0] d);
        return {d[6:0], 1'b0} ^ {8{d[7]}};
    endfunction

    function automatic logic [3:0] bitlen8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/compress_tile_predict_if.sv
// Output stream towards the bit-packing encoder: one residual plane per
// valid/ready handshake, tagged with its channel and residual bit width.
interface compress_tile_predict_if
    import compress_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF
);
    localparam int PW = 8 * TILE_SIZE * TILE_SIZE;

    logic          o_valid;
    logic          o_ready;
    logic [PW-1:0] o_data;
    logic [1:0]    o_chan;
    logic [3:0]    o_bits;
    logic          o_last;

    modport master (
        output o_valid,
        output o_data,
        output o_chan,
        output o_bits,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_chan,
        input  o_bits,
        input  o_last,
        output o_ready
    );

endinterface

// File: rtl/compress_tile_predict_plane_residual.sv
// Combinational spatial predictor for one plane: left neighbour within a
// row, upper neighbour at column 0, pixel 0 passed through raw.
module compress_plane_residual
    import compress_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF
) (
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0] i_plane,
    output logic [8*TILE_SIZE*TILE_SIZE-1:0] o_res,
    output logic [3:0]                       o_bits
);

    localparam int PIX = TILE_SIZE * TILE_SIZE;

    logic [7:0] w_z [PIX];
    logic [7:0] w_or;

    for (genvar k = 0; k < PIX; k++) begin : g_pix
        localparam int COL = k % TILE_SIZE;
        if (k == 0) begin : g_raw
            assign o_res[7:0] = i_plane[7:0];
            assign w_z[0]     = 8'h00;
        end else begin : g_pred
            localparam int REF = (COL > 0) ? (k - 1) : (k - TILE_SIZE);
            logic [7:0] w_d;
            assign w_d                = i_plane[8*k +: 8] - i_plane[8*REF +: 8];
            assign w_z[k]             = zigzag8(w_d);
            assign o_res[8*k +: 8]    = w_z[k];
        end
    end

    // Pixel 0 is a raw sample, so it never widens the residual field.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_or = 8'h00;
        for (int k = 1; k < PIX; k++) begin
            w_or = w_or | w_z[k];
        end
        o_bits = bitlen8(w_or);
    end

endmodule

// File: rtl/compress_tile_predict.sv
// Two-deep tile buffer feeding a channel sequencer; each output handshake
// carries one zigzag-coded residual plane of the tile at the buffer head.
module compress_tile_predict
    import compress_pkg::*;
#(
    parameter int TILE_SIZE = TILE_SIZE_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0] b_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0] g_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0] r_data,
    input  logic [8*TILE_SIZE*TILE_SIZE-1:0] a_data,
    output logic                             o_overflow,
    compress_tile_predict_if.master          out_if
);

    localparam int PW = 8 * TILE_SIZE * TILE_SIZE;

    typedef struct packed {
        logic [PW-1:0] a;
        logic [PW-1:0] r;
        logic [PW-1:0] g;
        logic [PW-1:0] b;
    } tile_t;

    tile_t       r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    chan_e       r_chan_idx;
    chan_e       w_chan_next;

    tile_t         w_in_tile;
    tile_t         w_head_tile;
    logic          w_empty;
    logic          w_head_valid;
    logic          w_load;
    logic          w_pop;
    logic          w_push;
    logic [PW-1:0] w_head_plane;
    logic [PW-1:0] w_res_plane;
    logic [3:0]    w_res_bits;

    // An empty buffer forwards the arriving tile straight to the predictor,
    // giving chan 0 one cycle after i_valid; the tile is still written into
    // the buffer so chans 1..3 come from storage.
    always_comb begin
        w_in_tile    = '{a: a_data, r: r_data, g: g_data, b: b_data};
        w_empty      = (r_count == 2'd0);
        w_head_valid = !w_empty || i_valid;
        w_head_tile  = w_empty ? w_in_tile : r_mem[r_rd_ptr];
        w_load       = w_head_valid && (!out_if.o_valid || out_if.o_ready);
        w_pop        = w_load && (r_chan_idx == CH_A);
        w_push       = i_valid && ((r_count != 2'd2) || w_pop);
    end

    always_comb begin
        w_head_plane = w_head_tile.b;
        case (r_chan_idx)
            CH_B: w_head_plane = w_head_tile.b;
            CH_G: w_head_plane = w_head_tile.g;
            CH_R: w_head_plane = w_head_tile.r;
            CH_A: w_head_plane = w_head_tile.a;
            default: w_head_plane = w_head_tile.b;
        endcase
    end

    compress_plane_residual #(
        .TILE_SIZE (TILE_SIZE)
    ) u_residual (
        .i_plane (w_head_plane),
        .o_res   (w_res_plane),
        .o_bits  (w_res_bits)
    );

    always_comb begin
        w_chan_next = r_chan_idx;
        if (w_load) begin
            w_chan_next = (r_chan_idx == CH_A) ? CH_B : chan_e'(r_chan_idx + 2'd1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_chan_idx <= CH_B;
        else     r_chan_idx <= w_chan_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            o_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (i_valid && !w_push) o_overflow <= 1'b1;
        end
    end

    // NOTE: tile storage has no reset; the count and pointers alone decide
    // which entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_tile;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_if.o_valid <= 1'b0;
            out_if.o_data  <= '0;
            out_if.o_chan  <= 2'd0;
            out_if.o_bits  <= 4'd0;
            out_if.o_last  <= 1'b0;
        end else if (w_load) begin
            out_if.o_valid <= 1'b1;
            out_if.o_data  <= w_res_plane;
            out_if.o_chan  <= r_chan_idx;
            out_if.o_bits  <= w_res_bits;
            out_if.o_last  <= (r_chan_idx == CH_A);
        end else if (out_if.o_valid && out_if.o_ready) begin
            out_if.o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_compress_tile_predict.sv
// Directed bench: table of tiles with hand-derived residual planes, plus
// back-to-back, backpressure/overflow and mid-tile reset sequences.
module tb_compress_tile_predict;
    import compress_pkg::*;

    localparam int TS  = 8;
    localparam int PIX = TS * TS;
    localparam int PW  = 8 * PIX;

    localparam int PAT_CONST40 = 0;
    localparam int PAT_RAMP    = 1;
    localparam int PAT_COL1    = 2;
    localparam int PAT_WRAP    = 3;
    localparam int PAT_ZERO    = 4;

    typedef struct {
        logic [PW-1:0] plane    [4];
        logic [PW-1:0] exp_data [4];
        logic [3:0]    exp_bits [4];
    } vec_t;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [PW-1:0] b_data, g_data, r_data, a_data;
    logic          o_overflow;
    int            n_checks;
    int            n_errors;
    vec_t          vecs [3];

    compress_tile_predict_if #(.TILE_SIZE(TS)) out_if ();

    compress_tile_predict #(.TILE_SIZE(TS)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .b_data     (b_data),
        .g_data     (g_data),
        .r_data     (r_data),
        .a_data     (a_data),
        .o_overflow (o_overflow),
        .out_if     (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each pattern comes with its residual plane worked out by hand.
    function automatic void make_pat(input int pat, output logic [PW-1:0] p,
                                     output logic [PW-1:0] e, output logic [3:0] bits);
        p = '0;
        e = '0;
        bits = 4'd0;
        for (int k = 0; k < PIX; k++) begin
            int col;
            col = k % TS;
            case (pat)
                PAT_CONST40: begin
                    p[8*k +: 8] = 8'h40;
                    e[8*k +: 8] = (k == 0) ? 8'h40 : 8'h00;
                    bits = 4'd0;
                end
                PAT_RAMP: begin
                    p[8*k +: 8] = 8'(k);
                    e[8*k +: 8] = (k == 0) ? 8'h00 : ((col > 0) ? 8'h02 : 8'h10);
                    bits = 4'd5;
                end
                PAT_COL1: begin
                    p[8*k +: 8] = (col == 1) ? 8'h00 : 8'hFF;
                    e[8*k +: 8] = (k == 0) ? 8'hFF : (col == 1) ? 8'h02 : (col == 2) ? 8'h01 : 8'h00;
                    bits = 4'd2;
                end
                PAT_WRAP: begin
                    p[8*k +: 8] = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : 8'h80;
                    e[8*k +: 8] = (k == 0) ? 8'hFF : (k == 1) ? 8'h02 : (k == 2) ? 8'hFF :
                                  (k == TS) ? 8'hFD : 8'h00;
                    bits = 4'd8;
                end
                default: begin
                    p[8*k +: 8] = 8'h00;
                    e[8*k +: 8] = 8'h00;
                    bits = 4'd0;
                end
            endcase
        end
    endfunction

    task automatic fill_vec(input int vi, input int pb, input int pg, input int pr, input int pa);
        int pats [4];
        pats = '{pb, pg, pr, pa};
        for (int c = 0; c < 4; c++) begin
            make_pat(pats[c], vecs[vi].plane[c], vecs[vi].exp_data[c], vecs[vi].exp_bits[c]);
        end
    endtask

    task automatic drive_tile(input int vi);
        b_data = vecs[vi].plane[0];
        g_data = vecs[vi].plane[1];
        r_data = vecs[vi].plane[2];
        a_data = vecs[vi].plane[3];
    endtask

    task automatic check_word(input string tag, input int vi, input int c);
        check($sformatf("%s valid", tag), PW'(out_if.o_valid), PW'(1));
        check($sformatf("%s chan", tag), PW'(out_if.o_chan), PW'(c));
        check($sformatf("%s data", tag), out_if.o_data, vecs[vi].exp_data[c]);
        check($sformatf("%s bits", tag), PW'(out_if.o_bits), PW'(vecs[vi].exp_bits[c]));
        check($sformatf("%s last", tag), PW'(out_if.o_last), PW'(c == 3));
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s o_valid", tag), PW'(out_if.o_valid), '0);
        check($sformatf("%s o_data", tag), out_if.o_data, '0);
        check($sformatf("%s o_chan", tag), PW'(out_if.o_chan), '0);
        check($sformatf("%s o_bits", tag), PW'(out_if.o_bits), '0);
        check($sformatf("%s o_last", tag), PW'(out_if.o_last), '0);
        check($sformatf("%s o_overflow", tag), PW'(o_overflow), '0);
    endtask

    initial begin
        int got;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        i_valid = 1'b0;
        b_data = '0;
        g_data = '0;
        r_data = '0;
        a_data = '0;
        out_if.o_ready = 1'b1;

        fill_vec(0, PAT_CONST40, PAT_CONST40, PAT_CONST40, PAT_CONST40);
        fill_vec(1, PAT_RAMP, PAT_COL1, PAT_WRAP, PAT_ZERO);
        fill_vec(2, PAT_WRAP, PAT_RAMP, PAT_ZERO, PAT_COL1);

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single tiles, sink always ready: chan 0 one cycle after the pulse.
        for (int vi = 0; vi < 3; vi++) begin
            drive_tile(vi);
            i_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                i_valid = 1'b0;
                check_word($sformatf("v%0d c%0d", vi, c), vi, c);
            end
            @(negedge clk);
            check($sformatf("v%0d idle", vi), PW'(out_if.o_valid), '0);
        end

        // Two tiles four cycles apart: eight consecutive words, no bubble.
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc == 0) drive_tile(1);
            if (cyc == 4) drive_tile(2);
            i_valid = (cyc == 0 || cyc == 4);
            if (cyc >= 1) check_word($sformatf("b2b w%0d", cyc - 1), (cyc <= 4) ? 1 : 2, (cyc - 1) % 4);
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("b2b idle", PW'(out_if.o_valid), '0);

        // Stalled sink for ten cycles while three tiles arrive.
        out_if.o_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive_tile((cyc == 4) ? 2 : 1);
            i_valid = (cyc == 0 || cyc == 4 || cyc == 8);
            if (cyc == 1 || cyc == 9) begin
                check_word($sformatf("bp frozen n%0d", cyc), 1, 0);
            end
            if (cyc == 8) check("bp no overflow yet", PW'(o_overflow), '0);
            if (cyc == 9) check("bp overflow", PW'(o_overflow), PW'(1));
            @(negedge clk);
        end
        i_valid = 1'b0;
        out_if.o_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (out_if.o_valid) begin
                check_word($sformatf("bp w%0d", got), (got < 4) ? 1 : 2, got % 4);
                got++;
            end
            @(negedge clk);
        end
        check("bp word count", PW'(got), PW'(8));
        check("bp drained", PW'(out_if.o_valid), '0);
        check("bp overflow sticky", PW'(o_overflow), PW'(1));

        // Reset after chan 1 has been accepted, then a fresh tile.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_tile(1);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check_word("mid c0", 1, 0);
        @(negedge clk);
        check_word("mid c1", 1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("mid reset");
        @(negedge clk);
        rst = 1'b0;
        check("post reset idle", PW'(out_if.o_valid), '0);
        drive_tile(2);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check_word("post c0", 2, 0);
        @(negedge clk);
        check_word("post c1", 2, 1);
        repeat (3) @(negedge clk);
        check("post idle", PW'(out_if.o_valid), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
